mux4_rr_scan_ctrl: RTL
======================

# mux4_rr_scan_ctrl

- Round-robin select controller that sits directly upstream of the 4:1 mux (`mux_4_1`).
- Arbitrates among four request lines and drives the mux select inputs `s1`/`s0`.
- Holds the select for a programmable settle time, then samples the mux output `y` into a register.
- Presents the sample downstream with a valid/ready handshake, tagged with the channel number.

## Interface

Parameters:
- `DWELL`, default 1: number of cycles the select is held before `y` is sampled. Legal range is 1..15; the simulation raises `$error` on any other value.

Ports (the clock is `clk`; the reset is `rst`, synchronous and active-high):
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous active-high reset
- `req`  in  4  per-channel sample request; bit k requests mux input ik
- `y`  in  1  mux output fed back from `mux_4_1`
- `out_ready`  in  1  downstream accepts the sample
- `s1`  out  1  mux select MSB, registered
- `s0`  out  1  mux select LSB, registered
- `out_valid`  out  1  `out_data`/`out_ch` hold a valid sample
- `out_data`  out  1  captured value of `y`
- `out_ch`  out  2  channel index of `out_data`
- `busy`  out  1  high whenever the state is not IDLE

## Operation

FSM states: IDLE, SELECT, VALID. Other state:
- 2-bit round-robin pointer `ptr`
- 4-bit dwell counter `cnt`
- registered grant `ch`; `{s1,s0}` always equals `ch`

IDLE:
- If `req`==0, stay in IDLE. `s1`/`s0` keep their last value.
- Otherwise, grant the first set bit in the search order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- On the grant: `ch` is set to the granted index, `cnt` is loaded with `DWELL-1`, and the state moves to SELECT.

SELECT:
- If `cnt`!=0, decrement `cnt` and stay in SELECT.
- If `cnt`==0: load `out_data` from `y`, set `out_ch` to `ch`, set `out_valid` to 1, and move to VALID.
- `req` is not examined. A request that drops mid-transaction still completes.

VALID:
- `out_valid`, `out_data`, `out_ch`, `s1` and `s0` are all held stable.
- On an edge with `out_ready`=1: clear `out_valid`, set `ptr` to `ch+1` mod 4 (so 3 wraps to 0), and move to IDLE.
- New requests are never granted in VALID. IDLE always costs one cycle between transactions.

Reset values (apply from any state, including mid-SELECT or mid-VALID, on the edge where `rst`=1):
- state IDLE
- `ptr`=0, `cnt`=0, `ch`=0
- `s1`=0, `s0`=0
- `out_valid`=0, `out_data`=0, `out_ch`=0
- `busy`=0

## Timing

- Edge E0: IDLE samples a nonzero `req`. After E0, `s1`/`s0` show the grant.
- Edge E`DWELL`: `y` is captured. By then `y` has seen the new select for exactly `DWELL` full cycles.
- `out_valid` rises after edge E`DWELL`. Latency from the sampled request to valid is `DWELL`+1 edges.
- Handshake completes on the first edge with `out_valid`=1 and `out_ready`=1. `out_ready` may be high early; the transfer then completes on the first VALID edge.
- Minimum transaction period is `DWELL`+2 cycles.
- `out_valid` may not drop without the handshake, except on reset.
- `busy` is combinational from the state and is high in SELECT and VALID.

## Configuration

Macro: `MUX4_RR_LOCK_EN`.
- Defined:
  - Adds port `lock`, in, 1 bit.
  - If `lock`=1 on the handshake edge, `ptr` is set to `ch` instead of `ch+1`. The same channel then wins next if its `req` bit is still set.
  - `lock` is ignored outside VALID.
- Undefined:
  - No `lock` port exists.
  - The pointer always advances by one, giving strict round-robin.

## Test plan

- Reset with `req`=4'b1111, `out_ready`=1: after `rst` deasserts, grants are ch 0,1,2,3,0. With mux inputs i0..i3 = 1,0,1,0, `out_data` returns 1,0,1,0,1.
- `DWELL`=3, `req`=4'b0100: `s1`/`s0` become 1/0 one edge after the request. `out_valid` rises 4 edges after the request, with `out_ch`=2 and `out_data` equal to i2.
- `req`=4'b1001 with `ptr`=1: ch 3 wins first, then ch 0. This checks the wrap of `ptr` from 3 to 0 via `ch+1`.
- `out_ready`=0 held for 5 cycles in VALID: `out_valid`, `out_data`, `out_ch`, `s1` and `s0` stay constant. When `out_ready`=1, the transfer completes in one edge and the state returns to IDLE.
- Drop `req` in mid-SELECT: the transaction still completes. Assert `rst` in mid-VALID: every output is at its reset value on the next edge and no handshake occurs.
- With `MUX4_RR_LOCK_EN` defined, `req`=4'b0011 and `lock`=1 at each handshake: ch 0 is granted repeatedly. When `lock` goes to 0, the next grant is ch 1.

Source files
------------

// File: rtl/mux4_rr_scan_ctrl.sv
// mux4_rr_scan_ctrl: round-robin select controller sitting upstream of a 4:1 mux.
// Grants one of four requests, holds s1/s0 for DWELL cycles, captures y and
// presents it downstream with out_valid/out_ready, tagged with the channel.
// Ports: clk, rst (sync, active-high), req[3:0], y, out_ready -> s1, s0,
//        out_valid, out_data, out_ch[1:0], busy.
// Optional macro MUX4_RR_LOCK_EN adds input 'lock': a handshake with lock=1
// leaves the pointer on the current channel instead of advancing past it.
module mux4_rr_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       y,
  input  logic       out_ready,
`ifdef MUX4_RR_LOCK_EN
  input  logic       lock,
`endif
  output logic       s1,
  output logic       s0,
  output logic       out_valid,
  output logic       out_data,
  output logic [1:0] out_ch,
  output logic       busy
);

  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux4_rr_scan_ctrl: DWELL=%0d outside legal range 1..15", DWELL);
  end

  localparam logic [3:0] CNT_INIT = 4'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    VALID  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [1:0] ch;
  logic [1:0] grant;
  logic       handshake;
  logic       hold_ptr;

  // Select lines are the registered grant itself, so they only move on a grant.
  assign s1 = ch[1];
  assign s0 = ch[0];

`ifdef MUX4_RR_LOCK_EN
  assign hold_ptr = lock;
`else
  assign hold_ptr = 1'b0;
`endif

  // Search order ptr, ptr+1, ptr+2, ptr+3 (mod 4). Walking the offsets from
  // the far end back to zero lets the nearest set request overwrite the rest.
  always_comb begin
    grant = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) grant = ptr + 2'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)          state_nxt = SELECT;
      SELECT:  if (cnt == 4'd0)   state_nxt = VALID;
      VALID:   if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    handshake = (state == VALID) && out_ready;
  end

  // Datapath registers: pointer, dwell counter, grant and output sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 2'd0;
      cnt       <= 4'd0;
      ch        <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_ch    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ch  <= grant;
            cnt <= CNT_INIT;
          end
        end
        SELECT: begin
          // req is deliberately ignored here: a granted transaction always completes.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_data  <= y;
            out_ch    <= ch;
            out_valid <= 1'b1;
          end
        end
        VALID: begin
          if (handshake) begin
            out_valid <= 1'b0;
            ptr       <= hold_ptr ? ch : ch + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
